reg_write_arbiter: RTL and testbench

- Round-robin arbiter sharing one enable-gated 4-bit register (async-clear DFF with enable) between NREQ requesters.
- Grants ownership of the register's write port for a burst of up to MAX_BURST writes.
- Drives the register's en and d inputs.
- Sits between requesting datapath blocks and the shared register. The register's own reset stays on its separate reset net.

---
 rtl/reg_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 34 +++
 rtl/reg_write_arbiter.sv | 139 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and widths for the register write arbiter.
package reg_arb_pkg;

    localparam int unsigned OWNER_W = 3;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set req bit scanning ptr, ptr+1, ... mod NREQ.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]    req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [NREQ-1:0]    pick,
    output logic [OWNER_W-1:0] idx,
    output logic               any
);

    int unsigned cand;

    // Walk the rotated priority order; the first requester found wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr) + k) % NREQ;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!any && req[i] && (cand == i)) begin
                    pick[i] = 1'b1;
                    idx     = OWNER_W'(i);
                    any     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin burst arbiter driving the write port (en/d) of one shared register.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      last,
    input  logic [NREQ*DW-1:0]   data,
    output logic [NREQ-1:0]      gnt,
    output logic [OWNER_W-1:0]   owner,
    output logic                 busy,
    output logic                 reg_en,
    output logic [DW-1:0]        reg_d
);

    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(MAX_BURST - 1);
    localparam logic [OWNER_W-1:0] LAST_IDX = OWNER_W'(NREQ - 1);

    state_e               state_q, state_d;
    logic [OWNER_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic                 busy_q, busy_d;

    logic [NREQ-1:0]      pick_oh;
    logic [OWNER_W-1:0]   pick_idx;
    logic                 pick_any;

    logic                 req_own;
    logic                 last_own;
    logic                 gnt_own;
    logic [DW-1:0]        data_own;
    logic                 beat;
    logic                 burst_end;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick_oh),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Select the current owner's request, last marker and data.
    always_comb begin
        req_own  = 1'b0;
        last_own = 1'b0;
        gnt_own  = 1'b0;
        data_own = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (owner_q == OWNER_W'(i)) begin
                req_own  = req[i];
                last_own = last[i];
                gnt_own  = gnt_q[i];
                data_own = data[i*DW +: DW];
            end
        end
    end

    assign beat      = (state_q == BURST) && gnt_own && req_own;
    assign burst_end = (state_q == BURST) &&
                       (!req_own || (beat && (last_own || (cnt_q == LAST_CNT))));

    // Next-state logic: arbitrate in IDLE, count beats and detect burst end in BURST.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (pick_any) begin
                    gnt_d   = pick_oh;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (burst_end) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + OWNER_W'(1);
                    state_d = IDLE;
                end else if (beat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Write port drive: same-cycle enable on a beat, suppressed while reset is high.
    always_comb begin
        reg_en = !reset && beat;
        reg_d  = reg_en ? data_own : '0;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural shared register on its own reset.
module tb_reg_write_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [15:0] data;
    logic [3:0]  gnt;
    logic [2:0]  owner;
    logic        busy;
    logic        reg_en;
    logic [3:0]  reg_d;

    logic        reg_clr;
    logic [3:0]  q;

    int errors = 0;
    int checks = 0;

    reg_write_arbiter #(
        .NREQ      (4),
        .DW        (4),
        .MAX_BURST (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .last   (last),
        .data   (data),
        .gnt    (gnt),
        .owner  (owner),
        .busy   (busy),
        .reg_en (reg_en),
        .reg_d  (reg_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared register: async clear, enable-gated capture.
    always_ff @(posedge clk or posedge reg_clr) begin
        if (reg_clr)     q <= 4'h0;
        else if (reg_en) q <= reg_d;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply this cycle's inputs, then let combinational outputs settle.
    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [15:0] d);
        req  = r;
        last = l;
        data = d;
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        reg_clr = 1'b1;
        req     = 4'b1111;
        last    = 4'b0000;
        data    = 16'h0000;
        #1;
        chk("rst_en_pre", 16'(reg_en), 16'h0);

        // Reset held for two cycles with all requests up.
        step(); #1;
        chk("rst1_gnt", 16'(gnt), 16'h0);
        chk("rst1_en", 16'(reg_en), 16'h0);
        chk("rst1_busy", 16'(busy), 16'h0);
        chk("rst1_owner", 16'(owner), 16'h0);
        step(); #1;
        chk("rst2_gnt", 16'(gnt), 16'h0);
        chk("rst2_en", 16'(reg_en), 16'h0);

        // Release: first IDLE cycle, then grant to requester 0.
        reset = 1'b0; reg_clr = 1'b0;
        drive(4'b1111, 4'b0000, 16'h0000);
        chk("idle_gnt", 16'(gnt), 16'h0);
        chk("idle_en", 16'(reg_en), 16'h0);
        step(); drive(4'b0001, 4'b0001, 16'h0003);
        chk("first_gnt", 16'(gnt), 16'h0001);
        chk("first_owner", 16'(owner), 16'h0);
        chk("first_busy", 16'(busy), 16'h1);
        chk("first_en", 16'(reg_en), 16'h1);
        chk("first_d", 16'(reg_d), 16'h3);

        // Single burst on requester 2 (ptr=1): A then 5 with last on beat 2.
        step(); drive(4'b0100, 4'b0000, 16'h0000);
        chk("gap0_gnt", 16'(gnt), 16'h0);
        chk("gap0_busy", 16'(busy), 16'h0);
        chk("gap0_en", 16'(reg_en), 16'h0);
        chk("gap0_q", 16'(q), 16'h3);
        step(); drive(4'b0100, 4'b0000, 16'h0A00);
        chk("sb1_gnt", 16'(gnt), 16'h0004);
        chk("sb1_owner", 16'(owner), 16'h2);
        chk("sb1_en", 16'(reg_en), 16'h1);
        chk("sb1_d", 16'(reg_d), 16'hA);
        step(); drive(4'b0100, 4'b0100, 16'h0500);
        chk("sb2_gnt", 16'(gnt), 16'h0004);
        chk("sb2_en", 16'(reg_en), 16'h1);
        chk("sb2_d", 16'(reg_d), 16'h5);
        chk("sb2_q", 16'(q), 16'hA);

        // Max-burst cut on requester 1 with requester 2 pending (ptr=3).
        step(); drive(4'b0110, 4'b0000, 16'h0000);
        chk("sb_end_gnt", 16'(gnt), 16'h0);
        chk("sb_end_en", 16'(reg_en), 16'h0);
        chk("sb_end_q", 16'(q), 16'h5);
        for (int b = 1; b <= 4; b++) begin
            step(); drive(4'b0110, 4'b0000, 16'(b) << 4);
            chk($sformatf("mb%0d_gnt", b), 16'(gnt), 16'h0002);
            chk($sformatf("mb%0d_en", b), 16'(reg_en), 16'h1);
            chk($sformatf("mb%0d_d", b), 16'(reg_d), 16'(b));
        end
        step(); drive(4'b0110, 4'b0000, 16'h0000);
        chk("mb_cut_gnt", 16'(gnt), 16'h0);
        chk("mb_cut_en", 16'(reg_en), 16'h0);
        chk("mb_cut_q", 16'(q), 16'h4);
        // Requester 2 wins next; it abandons immediately (no write).
        step(); drive(4'b0010, 4'b0000, 16'h0000);
        chk("mb_next_gnt", 16'(gnt), 16'h0004);
        chk("mb_abn_en", 16'(reg_en), 16'h0);
        chk("mb_abn_d", 16'(reg_d), 16'h0);
        step(); drive(4'b0000, 4'b0000, 16'h0000);
        chk("mb_abn_idle", 16'(gnt), 16'h0);
        step(); drive(4'b0000, 4'b0000, 16'h0000);
        chk("no_req_gnt", 16'(gnt), 16'h0);

        // One-cycle reset in IDLE restores ptr=0; then round-robin rotation.
        reset = 1'b1;
        step(); reset = 1'b0;
        drive(4'b1111, 4'b1111, 16'h4321);
        chk("rr_pre_gnt", 16'(gnt), 16'h0);
        for (int r = 0; r < 5; r++) begin
            step(); drive(4'b1111, 4'b1111, 16'h4321);
            chk($sformatf("rr%0d_gnt", r), 16'(gnt), 16'(1 << (r % 4)));
            chk($sformatf("rr%0d_d", r), 16'(reg_d), 16'((r % 4) + 1));
            if (r < 4) begin
                step(); drive(4'b1111, 4'b1111, 16'h4321);
                chk($sformatf("rr%0d_gap", r), 16'(gnt), 16'h0);
            end
        end
        step(); drive(4'b0000, 4'b0000, 16'h0000);
        chk("rr_end_gnt", 16'(gnt), 16'h0);
        chk("rr_end_q", 16'(q), 16'h1);

        // Abandon by owner 3 while requester 0 toggles req/last (ptr=1).
        step(); drive(4'b1000, 4'b0000, 16'h0000);
        chk("ab_idle_gnt", 16'(gnt), 16'h0);
        step(); drive(4'b1001, 4'b0001, 16'h700E);
        chk("ab1_gnt", 16'(gnt), 16'h0008);
        chk("ab1_owner", 16'(owner), 16'h3);
        chk("ab1_d", 16'(reg_d), 16'h7);
        step(); drive(4'b0001, 4'b0000, 16'h700E);
        chk("ab_drop_gnt", 16'(gnt), 16'h0008);
        chk("ab_drop_en", 16'(reg_en), 16'h0);
        chk("ab_drop_d", 16'(reg_d), 16'h0);
        step(); drive(4'b0001, 4'b0001, 16'h000E);
        chk("ab_idle2_gnt", 16'(gnt), 16'h0);
        chk("ab_q", 16'(q), 16'h7);
        step(); drive(4'b0001, 4'b0001, 16'h000E);
        chk("ab_next_gnt", 16'(gnt), 16'h0001);
        chk("ab_next_d", 16'(reg_d), 16'hE);

        // Reset during requester 1's second beat (ptr=1).
        step(); drive(4'b0010, 4'b0000, 16'h0000);
        chk("rm_idle_q", 16'(q), 16'hE);
        step(); drive(4'b0010, 4'b0000, 16'h0060);
        chk("rm1_gnt", 16'(gnt), 16'h0002);
        chk("rm1_d", 16'(reg_d), 16'h6);
        step();
        reset = 1'b1;
        drive(4'b0010, 4'b0000, 16'h00F0);
        chk("rm2_en", 16'(reg_en), 16'h0);
        chk("rm2_d", 16'(reg_d), 16'h0);
        step();
        reset = 1'b0;
        drive(4'b1010, 4'b0000, 16'h0000);
        chk("rm_gnt", 16'(gnt), 16'h0);
        chk("rm_busy", 16'(busy), 16'h0);
        chk("rm_owner", 16'(owner), 16'h0);
        chk("rm_q", 16'(q), 16'h6);
        // ptr=0 after reset, so requester 1 beats requester 3.
        step(); drive(4'b0000, 4'b0000, 16'h0000);
        chk("rm_ptr_gnt", 16'(gnt), 16'h0002);
        step(); #1;
        chk("fin_gnt", 16'(gnt), 16'h0);
        chk("fin_q", 16'(q), 16'h6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
